// File: rtl/tdc_event_collector_if.sv
// Bundles the TDC-side and readout-side signals of tdc_event_collector.
// The min-ToT filter ports exist only when TDC_COLLECTOR_TOT_FILTER_EN is defined.
interface tdc_event_collector_if #(
    parameter int N_CHANNELS = 4,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                      enable;
    logic [N_CHANNELS-1:0]     tdc_has_event;
    logic [32*N_CHANNELS-1:0]  tdc_timestamp;
    logic [32*N_CHANNELS-1:0]  tdc_tot;
    logic [N_CHANNELS-1:0]     tdc_clear;
    logic                      out_valid;
    logic                      out_ready;
    logic [67:0]               out_data;
    logic [LVL_W-1:0]          fifo_level;
    logic                      busy;
`ifdef TDC_COLLECTOR_TOT_FILTER_EN
    logic [31:0]               min_tot;
    logic [15:0]               filtered_count;
`endif

    modport master (
        input  enable, tdc_has_event, tdc_timestamp, tdc_tot, out_ready,
`ifdef TDC_COLLECTOR_TOT_FILTER_EN
        input  min_tot,
        output filtered_count,
`endif
        output tdc_clear, out_valid, out_data, fifo_level, busy
    );

    modport slave (
        output enable, tdc_has_event, tdc_timestamp, tdc_tot, out_ready,
`ifdef TDC_COLLECTOR_TOT_FILTER_EN
        output min_tot,
        input  filtered_count,
`endif
        input  tdc_clear, out_valid, out_data, fifo_level, busy
    );
endinterface

// File: rtl/tdc_event_collector.sv
// Round-robin collector of TDC hits into a FIFO-buffered 68-bit event stream.
// Define TDC_COLLECTOR_TOT_FILTER_EN to drop events whose ToT is below min_tot.
module tdc_event_collector #(
    parameter int N_CHANNELS   = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLEAR_CYCLES = 2
) (
    input logic                   clk,
    input logic                   reset,
    tdc_event_collector_if.master bus
);
    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CAPTURE  = 3'd1;
    localparam logic [2:0] S_PUSH     = 3'd2;
    localparam logic [2:0] S_CLEAR    = 3'd3;
    localparam logic [2:0] S_WAIT_LOW = 3'd4;

    logic [N_CHANNELS-1:0] r_sync1, r_req, r_tdc_clear, w_onehot;
    logic [2:0]            r_state, w_state_nxt;
    logic [CW-1:0]         r_ptr, r_grant, w_pick, w_idx;
    logic                  w_found, r_busy, w_clr_done;
    logic [31:0]           r_ts, r_tot;
    logic [KW-1:0]         r_clr_cnt;
    logic [67:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]         r_count, w_count_nxt;
    logic [67:0]           r_out_data, w_word;
    logic                  r_out_valid, w_full, w_pop, w_push, w_filtered;

    // two-flop synchroniser for the asynchronous hasEvent lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_req   <= '0;
        end else begin
            r_sync1 <= bus.tdc_has_event;
            r_req   <= r_sync1;
        end
    end

    // round-robin search: lowest offset from r_ptr wins
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = N_CHANNELS - 1; k >= 0; k--) begin
            w_idx = CW'((int'(r_ptr) + k) % N_CHANNELS);
            if (r_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // one-hot decode of the granted channel
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            w_onehot[i] = (CW'(i) == r_grant);
        end
    end

`ifdef TDC_COLLECTOR_TOT_FILTER_EN
    logic [15:0] r_filtered_count;
    assign w_filtered         = (r_tot < bus.min_tot);
    assign bus.filtered_count = r_filtered_count;

    // saturating count of events discarded by the ToT filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filtered_count <= 16'd0;
        end else if (r_state == S_PUSH && w_filtered && r_filtered_count != 16'hFFFF) begin
            r_filtered_count <= r_filtered_count + 16'd1;
        end
    end
`else
    assign w_filtered = 1'b0;
`endif

    assign w_clr_done = (r_clr_cnt == KW'(CLEAR_CYCLES - 1));
    assign w_full     = (r_count == LW'(FIFO_DEPTH));
    assign w_pop      = r_out_valid && bus.out_ready;
    assign w_push     = (r_state == S_PUSH) && !w_filtered && !w_full;
    assign w_word     = {4'(r_grant), r_ts, r_tot};

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (bus.enable && w_found) w_state_nxt = S_CAPTURE; else w_state_nxt = S_IDLE;
            S_CAPTURE:  w_state_nxt = S_PUSH;
            S_PUSH:     if (w_filtered || !w_full) w_state_nxt = S_CLEAR; else w_state_nxt = S_PUSH;
            S_CLEAR:    if (w_clr_done) w_state_nxt = S_WAIT_LOW; else w_state_nxt = S_CLEAR;
            S_WAIT_LOW: if (!r_req[r_grant]) w_state_nxt = S_IDLE; else w_state_nxt = S_WAIT_LOW;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, grant/pointer, captured data and clear pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_ts        <= 32'd0;
            r_tot       <= 32'd0;
            r_clr_cnt   <= '0;
            r_tdc_clear <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE && bus.enable && w_found) begin
                r_grant <= w_pick;
            end
            if (r_state == S_CAPTURE) begin
                r_ts  <= bus.tdc_timestamp[32*r_grant +: 32];
                r_tot <= bus.tdc_tot[32*r_grant +: 32];
            end
            if (r_state == S_PUSH && w_state_nxt == S_CLEAR) begin
                r_tdc_clear <= w_onehot;
                r_clr_cnt   <= '0;
            end else if (r_state == S_CLEAR) begin
                if (w_clr_done) r_tdc_clear <= '0;
                else            r_clr_cnt   <= r_clr_cnt + KW'(1);
            end
            if (r_state == S_WAIT_LOW && !r_req[r_grant]) begin
                r_ptr <= (r_grant == CW'(N_CHANNELS - 1)) ? '0 : r_grant + CW'(1);
            end
        end
    end

    // occupancy after this cycle's push and pop
    always_comb begin
        if (w_push && !w_pop)      w_count_nxt = r_count + LW'(1);
        else if (!w_push && w_pop) w_count_nxt = r_count - LW'(1);
        else                       w_count_nxt = r_count;
    end

    // FIFO storage (contents are don't-care while empty)
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    // FIFO pointers, level and registered head word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 68'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            if (w_push && (r_count == '0 || (r_count == LW'(1) && w_pop))) begin
                r_out_data <= w_word;
            end else if (w_pop && r_count > LW'(1)) begin
                r_out_data <= r_mem[r_rd_ptr + AW'(1)];
            end
        end
    end

    assign bus.tdc_clear  = r_tdc_clear;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.fifo_level = r_count;
    assign bus.busy       = r_busy;
endmodule

// File: doc/tdc_event_collector.md
Name: tdc_event_collector

Overview:
Collects finished hits from N_CHANNELS TDC channel instances and serialises them into one event stream.
- Per channel it consumes hasEvent, timestamp and timeOverThreshold, and drives that channel's clear.
- Output is a FIFO-buffered valid/ready stream to the DAQ readout/packetiser.
- Lives in the system clock domain; TDC outputs are treated as asynchronous.

Parameters:
N_CHANNELS, 4, number of TDC channels served (1..16)
FIFO_DEPTH, 16, event FIFO entries; power of 2, >= 2
CLEAR_CYCLES, 2, clk cycles each clear pulse is held high (>= 1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = new grants allowed; 0 = finish current event, then hold in IDLE
tdc_has_event  in  N_CHANNELS  per-channel hasEvent (asynchronous)
tdc_timestamp  in  32*N_CHANNELS  per-channel timestamp, channel i at [32*i+31:32*i]
tdc_tot  in  32*N_CHANNELS  per-channel timeOverThreshold, same packing
tdc_clear  out  N_CHANNELS  per-channel clear pulse
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the head word
out_data  out  68  {chan[3:0], timestamp[31:0], tot[31:0]}
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: tdc_clear=0, out_valid=0, fifo_level=0, busy=0, out_data=0. FSM goes to IDLE, round-robin pointer to 0, synchronisers to 0.
- Each tdc_has_event bit passes a 2-flop synchroniser (req_s). Data buses are not synchronised; they are stable while hasEvent is held.
- Arbitration: round-robin. Search starts at pointer and wraps at N_CHANNELS-1 to 0. After a channel is served, pointer = served+1, mod N_CHANNELS.
- IDLE: if enable and any req_s, latch the granted index g and go to CAPTURE.
- CAPTURE (1 cycle): register tdc_timestamp[g] and tdc_tot[g]; go to PUSH.
- PUSH: if FIFO not full, write {g, ts, tot} and go to CLEAR. If full, stall in PUSH; tdc_clear stays 0, so the channel keeps its hit and nothing is dropped.
- CLEAR: tdc_clear[g]=1 for exactly CLEAR_CYCLES cycles; all other clear bits stay 0. Then go to WAIT_LOW.
- WAIT_LOW: stay until req_s[g]==0, then go to IDLE and advance pointer. This prevents double capture of one hit.
- Latency: hasEvent rise to FIFO write is 5 clk with an empty FIFO (2 sync + IDLE + CAPTURE + PUSH). The word is visible on out_valid the cycle after the write.
- Minimum per-event period: 3 + CLEAR_CYCLES + 2 (WAIT_LOW sync) cycles.
- FIFO: out_data is the registered head. Pop when out_valid && out_ready.
  - Simultaneous push and pop: both occur and fifo_level is unchanged.
  - Push is evaluated against the full flag before the same-cycle pop (no fall-through when full).
  - The first word appears on out_valid 1 cycle after the write into an empty FIFO.
- enable deasserted mid-event: the current event completes through WAIT_LOW; no further grants.
- Reset mid-operation (any state): tdc_clear drops to 0 immediately, the FIFO is emptied, and the FSM returns to IDLE. The TDC keeps its hit and is re-served after reset.
- A channel with has_event stuck high is re-granted only after it drops. The other channels are still served after it, because WAIT_LOW is per-grant and the pointer advances.

Optional Feature:
TDC_COLLECTOR_TOT_FILTER_EN
- Defined: adds input min_tot[31:0] and output filtered_count[15:0] (reset 0, saturates at 0xFFFF).
  - In PUSH, an event with tot < min_tot is not written. It still goes through CLEAR/WAIT_LOW, and filtered_count increments by 1.
  - A filtered event never stalls on FIFO full.
- Undefined: the ports are absent and every event is written.

Test Plan:
- Single hit, ch1 timestamp=0x1000, tot=0x25: out_data={1,0x1000,0x25} valid at cycle 6; tdc_clear[1] high for 2 cycles after PUSH; fifo_level returns to 0 after pop.
- ch0 and ch3 hasEvent rise same cycle, pointer=0: ch0 then ch3 in FIFO order; each clear pulse is 2 cycles, non-overlapping. A following ch0 re-hit is served after ch3.
- out_ready=0, 17 sequential hits, FIFO_DEPTH=16: fifo_level=16; 17th channel's clear never asserts and FSM stays in PUSH. One pop writes the 17th, then it is cleared.
- Assert reset during CLEAR of ch2: tdc_clear=0 the same cycle, out_valid=0. After release with ch2 hasEvent still high, ch2 is captured exactly once.
- Filter enabled, min_tot=0x10, hits tot=0x0F then 0x10: only the 0x10 event is output; filtered_count=1; both channels are cleared.
- enable=0 with pending hits on ch1, ch2: no grant and no clear, busy=0. On enable=1, ch1 is served then ch2.
